// File: rtl/instr_encoder.sv
// Packs decoded control bundles back into 32-bit instruction words and streams
// them into instruction memory at consecutive addresses; illegal bundles are counted.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegDst,
    input  logic              RegWrite,
    input  logic              ALU_src,
    input  logic              MemWrite,
    input  logic              MemToReg,
    input  logic              branch,
    input  logic [2:0]        ALU_op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err,
    output logic [7:0]        bad_count
);

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    // Returns {legal, opcode}; ctrl is {RegDst, RegWrite, ALU_src, MemWrite, MemToReg, branch, ALU_op}.
    function automatic logic [6:0] opcode_of(input logic [8:0] ctrl);
        case (ctrl)
            9'b110000_000: opcode_of = {1'b1, 6'h00};
            9'b110000_001: opcode_of = {1'b1, 6'h01};
            9'b110000_010: opcode_of = {1'b1, 6'h02};
            9'b110000_011: opcode_of = {1'b1, 6'h06};
            9'b110000_100: opcode_of = {1'b1, 6'h07};
            9'b011010_010: opcode_of = {1'b1, 6'h08};
            9'b101100_010: opcode_of = {1'b1, 6'h0A};
            9'b100001_011: opcode_of = {1'b1, 6'h0E};
            default:       opcode_of = 7'h00;
        endcase
    endfunction

    function automatic logic [31:0] pack_word(input logic [5:0] op, input logic rtype,
                                              input logic [4:0] f_rs, input logic [4:0] f_rt,
                                              input logic [4:0] f_rd, input logic [15:0] f_imm);
        if (rtype)
            pack_word = {op, f_rs, f_rt, f_rd, 11'b0};
        else
            pack_word = {op, f_rs, f_rt, f_imm};
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [8:0]        ctrl;
    logic [6:0]        lookup;
    logic              accept;
    logic [ADDR_W:0]   reserved;
    logic [ADDR_W-1:0] wr_ptr;
    logic              vld_p1;
    logic              legal_p1;
    logic [31:0]       word_p1;

    assign ctrl     = {RegDst, RegWrite, ALU_src, MemWrite, MemToReg, branch, ALU_op};
    assign lookup   = opcode_of(ctrl);
    assign in_ready = !rst && !clear && (reserved < CAPACITY);
    assign accept   = in_valid && in_ready;
    assign full     = (word_count == CAPACITY);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            reserved   <= '0;
            vld_p1     <= 1'b0;
            legal_p1   <= 1'b0;
            wr_ptr     <= '0;
            imem_we    <= 1'b0;
            word_count <= '0;
            err        <= 1'b0;
            bad_count  <= 8'd0;
        end else begin
            // stage 1: accept, classify
            vld_p1   <= accept;
            legal_p1 <= lookup[6];
            if (accept && lookup[6])
                reserved <= reserved + 1'b1;
            // stage 2: issue write or record the illegal bundle
            imem_we <= vld_p1 && legal_p1;
            if (vld_p1 && legal_p1)
                wr_ptr <= wr_ptr + 1'b1;
            if (vld_p1 && !legal_p1) begin
                err       <= 1'b1;
                bad_count <= sat_inc8(bad_count);
            end
            if (imem_we)
                word_count <= word_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            word_p1 <= pack_word(lookup[5:0], !ALU_src && !branch, rs, rt, rd, imm);
    end

    // Address and data hold between writes; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else if (!clear && vld_p1 && legal_p1) begin
            imem_addr  <= wr_ptr;
            imem_wdata <= word_p1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a transaction-level
// reference model (address = legal words accepted before it since clear).
module tb_instr_encoder;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
    } bundle_t;

    typedef struct {
        bit          legal;
        int          addr;
        logic [31:0] word;
        logic [8:0]  ctrl;
    } pend_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    bundle_t           cur = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              full;
    logic              err;
    logic [7:0]        bad_count;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .RegDst(cur.ctrl[8]), .RegWrite(cur.ctrl[7]), .ALU_src(cur.ctrl[6]),
        .MemWrite(cur.ctrl[5]), .MemToReg(cur.ctrl[4]), .branch(cur.ctrl[3]),
        .ALU_op(cur.ctrl[2:0]), .rs(cur.rs), .rt(cur.rt), .rd(cur.rd), .imm(cur.imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .full(full), .err(err), .bad_count(bad_count)
    );

    always #5 clk = ~clk;

    // The eight legal bundles and their opcodes.
    logic [8:0] leg_ctrl [8] = '{9'b110000000, 9'b110000001, 9'b110000010, 9'b110000011,
                                 9'b110000100, 9'b011010010, 9'b101100010, 9'b100001011};
    int         leg_op   [8] = '{0, 1, 2, 6, 7, 8, 10, 14};

    localparam logic [8:0] C_ADD = 9'b110000010;
    localparam logic [8:0] C_LW  = 9'b011010010;
    localparam logic [8:0] C_BNE = 9'b100001011;
    localparam logic [8:0] C_BAD = 9'b110000111;

    int n_checks = 0;
    int n_fail   = 0;
    int ecount   = 0;

    // Model state as it should appear after the most recent edge.
    bit          m_we = 0;
    int          m_addr = 0;
    logic [31:0] m_wdata = 0;
    int          m_wc = 0;
    bit          m_err = 0;
    int          m_bad = 0;
    int          m_res = 0;
    logic [8:0]  m_ctrl = 0;
    pend_t       pend[$];
    wr_t         writes[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, ecount);
        end
    endtask

    function automatic bundle_t mk(input logic [8:0] c, input int a, input int b, input int d, input int i);
        bundle_t r;
        r.ctrl = c; r.rs = 5'(a); r.rt = 5'(b); r.rd = 5'(d); r.imm = 16'(i);
        return r;
    endfunction

    task automatic ref_encode(input bundle_t b, output bit legal, output logic [31:0] w);
        int unsigned op;
        legal = 0;
        op = 0;
        for (int i = 0; i < 8; i++)
            if (b.ctrl == leg_ctrl[i]) begin
                legal = 1;
                op = leg_op[i];
            end
        if (b.ctrl[6] == 1'b0 && b.ctrl[3] == 1'b0)
            w = op * 32'd67108864 + b.rs * 32'd2097152 + b.rt * 32'd65536 + b.rd * 32'd2048;
        else
            w = op * 32'd67108864 + b.rs * 32'd2097152 + b.rt * 32'd65536 + b.imm;
    endtask

    // Independent decoder: opcode back to control bits.
    function automatic logic [8:0] decode_op(input logic [5:0] op);
        for (int i = 0; i < 8; i++)
            if (int'(op) == leg_op[i]) return leg_ctrl[i];
        return 9'h1FF;
    endfunction

    task automatic step(input bit r, input bit c, input bit v, input bundle_t b);
        bit          rdy;
        bit          legal;
        logic [31:0] w;
        pend_t       p;
        @(negedge clk);
        chk("imem_we", imem_we, m_we);
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, m_wdata);
        chk("word_count", word_count, m_wc);
        chk("full", full, m_wc == DEPTH);
        chk("err", err, m_err);
        chk("bad_count", bad_count, m_bad);
        if (imem_we === 1'b1) begin
            writes.push_back('{int'(imem_addr), imem_wdata, ecount});
            chk("roundtrip", decode_op(imem_wdata[31:26]), m_ctrl);
        end
        rst = r; clear = c; in_valid = v; cur = b;
        #1;
        rdy = !r && !c && (m_res < DEPTH);
        chk("in_ready", in_ready, rdy);
        if (r || c) begin
            m_we = 0;
            if (r) begin
                m_addr = 0;
                m_wdata = 0;
            end
            m_wc = 0; m_err = 0; m_bad = 0; m_res = 0;
            pend.delete();
        end else begin
            if (m_we) m_wc++;
            m_we = 0;
            if (pend.size() > 0) begin
                p = pend.pop_front();
                if (p.legal) begin
                    m_we = 1; m_addr = p.addr; m_wdata = p.word; m_ctrl = p.ctrl;
                end else begin
                    m_err = 1;
                    if (m_bad < 255) m_bad++;
                end
            end
            if (v && rdy) begin
                ref_encode(b, legal, w);
                pend.push_back('{legal, m_res, w, b.ctrl});
                if (legal) m_res++;
            end
        end
        ecount++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0);
    endtask

    task automatic restart();
        step(0, 1, 0, '0);
        writes.delete();
    endtask

    initial begin
        bundle_t rb;
        repeat (2) @(posedge clk);
        step(1, 0, 1, mk(C_ADD, 1, 1, 1, 0));
        step(1, 0, 0, '0);

        // Single ADD
        step(0, 0, 1, mk(C_ADD, 1, 2, 3, 0));
        idle(3);
        chk("add_nwr", writes.size(), 1);
        if (writes.size() == 1) begin
            chk("add_addr", writes[0].addr, 0);
            chk("add_data", writes[0].data, 32'h08221800);
        end
        chk("add_wc", word_count, 1);

        // Mixed stream, back to back
        restart();
        step(0, 0, 1, mk(C_LW, 4, 5, 9, 16'h0010));
        step(0, 0, 1, mk(C_BNE, 1, 2, 9, 16'hFFFE));
        idle(3);
        chk("mix_nwr", writes.size(), 2);
        if (writes.size() == 2) begin
            chk("mix_a0", writes[0].addr, 0);
            chk("mix_d0", writes[0].data, 32'h20850010);
            chk("mix_a1", writes[1].addr, 1);
            chk("mix_d1", writes[1].data, 32'h3822FFFE);
            chk("mix_consec", writes[1].cyc - writes[0].cyc, 1);
        end

        // Illegal bundle between two ADDs
        restart();
        step(0, 0, 1, mk(C_ADD, 1, 2, 3, 0));
        step(0, 0, 1, mk(C_BAD, 1, 2, 3, 0));
        step(0, 0, 1, mk(C_ADD, 4, 5, 6, 0));
        idle(3);
        chk("ill_err", err, 1);
        chk("ill_bad", bad_count, 1);
        chk("ill_nwr", writes.size(), 2);
        if (writes.size() == 2) begin
            chk("ill_a0", writes[0].addr, 0);
            chk("ill_a1", writes[1].addr, 1);
        end

        // Fill with in_valid held high
        restart();
        for (int i = 0; i < 6; i++) step(0, 0, 1, mk(C_ADD, i, i + 1, i + 2, 0));
        chk("fill_ready", in_ready, 0);
        idle(3);
        chk("fill_nwr", writes.size(), DEPTH);
        for (int i = 0; i < writes.size(); i++) chk("fill_addr", writes[i].addr, i);
        chk("fill_full", full, 1);
        chk("fill_wc", word_count, DEPTH);

        // Clear on the edge after an acceptance
        restart();
        step(0, 0, 1, mk(C_ADD, 7, 7, 7, 0));
        step(0, 1, 1, mk(C_ADD, 8, 8, 8, 0));
        idle(3);
        chk("clr_nwr", writes.size(), 0);
        step(0, 0, 1, mk(C_ADD, 9, 9, 9, 0));
        idle(3);
        chk("clr_nwr2", writes.size(), 1);
        if (writes.size() == 1) chk("clr_addr", writes[0].addr, 0);
        chk("clr_err", err, 0);
        chk("clr_bad", bad_count, 0);

        // All legal bundles, round-tripped through the decoder in step
        for (int g = 0; g < 2; g++) begin
            restart();
            for (int i = 0; i < 4; i++) step(0, 0, 1, mk(leg_ctrl[g * 4 + i], i, i + 3, i + 5, 16'h1234 + i));
            idle(3);
            chk("rt_nwr", writes.size(), 4);
        end

        // bad_count saturation
        restart();
        for (int i = 0; i < 260; i++) step(0, 0, 1, mk(C_BAD, 0, 0, 0, 0));
        idle(2);
        chk("sat_bad", bad_count, 255);

        // Random traffic
        restart();
        for (int i = 0; i < 600; i++) begin
            rb = mk(9'($urandom), $urandom, $urandom, $urandom, $urandom);
            if ($urandom_range(9) < 7) rb.ctrl = leg_ctrl[$urandom_range(7)];
            step($urandom_range(99) < 1, $urandom_range(99) < 4, $urandom_range(9) < 7, rb);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Writer-side counterpart of the opcode-to-control decoder. The block accepts a decoded control bundle (RegDst, RegWrite, ALU_src, MemWrite, MemToReg, branch, ALU_op) plus register and immediate fields. It reconstructs the 6-bit opcode, packs a 32-bit instruction word, and writes the words sequentially into instruction memory. It sits between the test-program generator or loader and the instruction memory, so the decoder can be checked by round-trip.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width. Depth is 2^ADDR_W.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clear` in 1: synchronous restart. Zeroes the pointer, counters and error flag.
- `in_valid` in 1: the request bundle is valid.
- `in_ready` out 1: the block can accept a request.
- `RegDst`, `RegWrite`, `ALU_src`, `MemWrite`, `MemToReg`, `branch` in 1 each: control bundle.
- `ALU_op` in 3: ALU operation code.
- `rs`, `rt`, `rd` in 5 each: register fields.
- `imm` in 16: immediate or branch offset.
- `imem_we` out 1: write strobe. It is a registered output.
- `imem_addr` out ADDR_W: word address of the write.
- `imem_wdata` out 32: encoded instruction word.
- `word_count` out ADDR_W+1: number of words written since reset or clear.
- `full` out 1: word_count equals 2^ADDR_W.
- `err` out 1: sticky flag. Set when an illegal bundle is seen.
- `bad_count` out 8: number of illegal bundles. Saturates at 255.

## Operation
- **Legal bundles.** Each bundle below is listed as RegDst, RegWrite, ALU_src, MemWrite, MemToReg, branch, then ALU_op, followed by the opcode it encodes to.
  - AND: 1,1,0,0,0,0, ALU_op 000 → opcode 0x00.
  - OR: 1,1,0,0,0,0, ALU_op 001 → opcode 0x01.
  - ADD: 1,1,0,0,0,0, ALU_op 010 → opcode 0x02.
  - SUB: 1,1,0,0,0,0, ALU_op 011 → opcode 0x06.
  - SLT: 1,1,0,0,0,0, ALU_op 100 → opcode 0x07.
  - LW: 0,1,1,0,1,0, ALU_op 010 → opcode 0x08.
  - SW: 1,0,1,1,0,0, ALU_op 010 → opcode 0x0A.
  - BNE: 1,0,0,0,0,1, ALU_op 011 → opcode 0x0E.
- **Illegal bundles.** Any other combination of the 9 bits is illegal.
- **Word format.**
  - R-type (ALU_src=0 and branch=0): {opcode, rs, rt, rd, 11'b0}.
  - I-type (LW, SW, BNE): {opcode, rs, rt, imm}. The rd input is ignored.
- **Handshake.**
  - A transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - in_ready = !rst && (reserved < 2^ADDR_W). `reserved` counts the legal words accepted, including the one in flight.
- **Pipeline.** There are two stages.
  - Stage 1 is registered on acceptance: encode and legality check.
  - Stage 2 drives imem_we, imem_addr and imem_wdata for one cycle.
  - Back-to-back acceptance is supported at 1 word per cycle.
- **Legal transfer.**
  - The word is written at address wr_ptr. wr_ptr then increments by 1.
  - word_count increments on the cycle imem_we is high.
  - wr_ptr does not wrap, because acceptance stops at full.
- **Illegal transfer.**
  - The transfer is consumed, since in_ready is unaffected.
  - No write occurs and wr_ptr is unchanged.
  - err is set; bad_count increments, saturating.
- **Clear.**
  - clear has priority over acceptance in the same cycle. A simultaneous in_valid is not accepted; in_ready is deasserted while clear=1.
  - Any stage-2 word not yet written is dropped: imem_we is 0 on the cycle following clear.
  - wr_ptr, reserved, word_count, err and bad_count all return to 0.
- **Reset.** rst has the same effect as clear, and also zeroes all output registers.

## Timing
- **Reset values.** imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, full=0, err=0, bad_count=0, in_ready=0 while rst=1.
- **Latency.** A bundle accepted at edge k produces imem_we=1 in the cycle between edges k+1 and k+2. The write is committed at edge k+2.
- **Counter update.**
  - word_count and full update at edge k+2.
  - in_ready falls combinationally in the cycle after the acceptance that makes reserved = 2^ADDR_W.
- **Error flag.** err and bad_count update at edge k+1 for an illegal bundle accepted at edge k.
- **Output when idle.** imem_addr and imem_wdata hold their last values when imem_we=0.

## Test plan
- **Single ADD.** After reset, ADD bundle with rs=1, rt=2, rd=3 → one imem_we pulse with addr 0 and wdata 0x08221800 two edges after acceptance; word_count becomes 1.
- **Mixed stream.** LW (rs=4, rt=5, imm=0x0010) then BNE (rs=1, rt=2, imm=0xFFFE), sent back-to-back → writes 0x20850010 at addr 0 and 0x3822FFFE at addr 1 on consecutive cycles.
- **Illegal bundle.** ALU_op=111 with R-type controls, placed between two legal ADDs → err=1 and bad_count=1; the two ADDs land at addrs 0 and 1 with no gap.
- **Fill.** With ADDR_W=2, hold in_valid high for 6 legal bundles → exactly 4 writes (addrs 0..3); in_ready=0 after the 4th acceptance; full=1 and word_count=4.
- **Clear mid-stream.** Assert clear on the edge after an acceptance → no imem_we is issued for that word; the next accepted word is written at addr 0, and err, bad_count and word_count are 0.
- **Full decode round-trip.** All 8 legal bundles encoded, then fed to the control decoder → the regenerated control bits match the inputs exactly.
